// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start bit, 8 data bits LSB first, optional 9th bit (TB8), stop bit.
// The bit period is clamped and latched when a frame is accepted; all outputs come straight from flops.
module uart_tx_frame #(
    parameter int DATA_BITS    = 8,
    parameter int PERIOD_WIDTH = 16,
    parameter int MIN_PERIOD   = 104,
    parameter int MAX_PERIOD   = 10000
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    input  logic [PERIOD_WIDTH-1:0] baud_period,
    input  logic                    ninth_en,
    input  logic [DATA_BITS-1:0]    tx_data,
    input  logic                    tx_bit8,
    input  logic                    tx_start,
    output logic                    txd,
    output logic                    tx_busy,
    output logic                    tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [PERIOD_WIDTH-1:0] MIN_P    = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] MAX_P    = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_NINTH = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    tx_state_e                 state_r;
    logic [PERIOD_WIDTH-1:0]   period_r;
    logic [PERIOD_WIDTH-1:0]   count_r;
    logic [IDX_W-1:0]          bit_idx_r;
    logic [DATA_BITS:0]        shift_r;
    logic                      ninth_r;
    logic                      txd_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      last_s;
    logic                      pre_last_s;

    // Clamp a requested bit period into the supported baud range (0 lands on the floor).
    function automatic logic [PERIOD_WIDTH-1:0] clamp_period(input logic [PERIOD_WIDTH-1:0] raw);
        logic [PERIOD_WIDTH-1:0] res;
        if (raw < MIN_P) begin
            res = MIN_P;
        end else if (raw > MAX_P) begin
            res = MAX_P;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    // Bit-timer decodes: last cycle of a bit, and the cycle before it (used to register tx_done).
    always_comb begin
        last_s     = 1'b0;
        pre_last_s = 1'b0;
        last_s     = (count_r == (period_r - PERIOD_WIDTH'(1)));
        pre_last_s = (count_r == (period_r - PERIOD_WIDTH'(2)));
    end

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_r   <= ST_IDLE;
            period_r  <= MIN_P;
            count_r   <= {PERIOD_WIDTH{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            shift_r   <= {(DATA_BITS + 1){1'b0}};
            ninth_r   <= 1'b0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (tx_start) begin
                        period_r  <= clamp_period(baud_period);
                        shift_r   <= {tx_bit8, tx_data};
                        ninth_r   <= ninth_en;
                        count_r   <= {PERIOD_WIDTH{1'b0}};
                        bit_idx_r <= {IDX_W{1'b0}};
                        txd_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_START;
                    end else begin
                        txd_r  <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (last_s) begin
                        count_r   <= {PERIOD_WIDTH{1'b0}};
                        bit_idx_r <= {IDX_W{1'b0}};
                        txd_r     <= shift_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        count_r <= count_r + PERIOD_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    // shift_r[0] is on the line now, so shift_r[1] is always the next bit (TB8 after bit 7).
                    if (last_s) begin
                        count_r <= {PERIOD_WIDTH{1'b0}};
                        shift_r <= {1'b1, shift_r[DATA_BITS:1]};
                        if (bit_idx_r == LAST_IDX) begin
                            if (ninth_r) begin
                                txd_r   <= shift_r[1];
                                state_r <= ST_NINTH;
                            end else begin
                                txd_r   <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        count_r <= count_r + PERIOD_WIDTH'(1);
                    end
                end
                ST_NINTH: begin
                    if (last_s) begin
                        count_r <= {PERIOD_WIDTH{1'b0}};
                        txd_r   <= 1'b1;
                        state_r <= ST_STOP;
                    end else begin
                        count_r <= count_r + PERIOD_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    // tx_start is not looked at here, so a request coincident with tx_done is dropped.
                    if (last_s) begin
                        count_r <= {PERIOD_WIDTH{1'b0}};
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        count_r <= count_r + PERIOD_WIDTH'(1);
                        done_r  <= pre_last_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= {PERIOD_WIDTH{1'b0}};
                    txd_r   <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign txd     = txd_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus randomized frames checked
// cycle by cycle against a frame model built from the bit list and the clamped period.
module tb_uart_tx_frame;

    localparam int MIN_P = 104;
    localparam int MAX_P = 10000;

    logic        clk;
    logic        sync_reset;
    logic [15:0] baud_period;
    logic        ninth_en;
    logic [7:0]  tx_data;
    logic        tx_bit8;
    logic        tx_start;
    logic        txd;
    logic        tx_busy;
    logic        tx_done;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_frame dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .baud_period (baud_period),
        .ninth_en    (ninth_en),
        .tx_data     (tx_data),
        .tx_bit8     (tx_bit8),
        .tx_start    (tx_start),
        .txd         (txd),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_period(input int baud);
        if (baud < MIN_P) return MIN_P;
        if (baud > MAX_P) return MAX_P;
        return baud;
    endfunction

    // Called at a negedge; request is sampled on the next posedge, returns at the negedge of frame cycle 0.
    task automatic start_req(input int baud, input logic [7:0] d, input logic b8, input logic nin);
        baud_period = 16'(baud);
        tx_data     = d;
        tx_bit8     = b8;
        ninth_en    = nin;
        tx_start    = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Watches one whole frame from cycle 0; returns at the negedge of the first cycle after the frame.
    task automatic watch_frame(input string name, input logic [7:0] d, input logic b8, input logic nin,
                               input int baud, input int inject_at, input logic scramble);
        int   p, nbits, len, done_cnt, done_at, busy_cnt;
        int   good[11];
        logic expb[11];
        p     = model_period(baud);
        nbits = nin ? 11 : 10;
        len   = nbits * p;
        expb[0] = 1'b0;
        for (int i = 0; i < 8; i++) expb[i + 1] = d[i];
        expb[9]  = b8;
        expb[nbits - 1] = 1'b1;
        for (int b = 0; b < 11; b++) good[b] = 0;
        done_cnt = 0;
        done_at  = -1;
        busy_cnt = 0;
        for (int c = 0; c < len; c++) begin
            if (txd === expb[c / p]) good[c / p]++;
            if (tx_busy === 1'b1) busy_cnt++;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if (c == inject_at) begin
                tx_start    = 1'b1;
                tx_data     = 8'hFF;
                tx_bit8     = ~b8;
                ninth_en    = ~nin;
                baud_period = 16'($urandom_range(0, 500));
            end else begin
                tx_start = 1'b0;
                if (scramble) begin
                    tx_data     = 8'($urandom);
                    tx_bit8     = 1'($urandom);
                    ninth_en    = 1'($urandom);
                    baud_period = 16'($urandom);
                end
            end
            @(negedge clk);
        end
        tx_start = 1'b0;
        for (int b = 0; b < nbits; b++)
            check_val($sformatf("%s_bit%0d_cycles", name, b), good[b], p);
        check_val({name, "_busy_cycles"}, busy_cnt, len);
        check_val({name, "_done_count"}, done_cnt, 1);
        check_val({name, "_done_pos"}, done_at, len - 1);
        check_val({name, "_busy_end"}, tx_busy, 1'b0);
        check_val({name, "_txd_end"}, txd, 1'b1);
        check_val({name, "_done_end"}, tx_done, 1'b0);
    endtask

    initial begin
        int         rb, gap, inj, c, lows, dones;
        logic [7:0] rd;
        logic       r8, rn;

        sync_reset  = 1'b1;
        baud_period = 16'd0;
        ninth_en    = 1'b0;
        tx_data     = 8'h00;
        tx_bit8     = 1'b0;
        tx_start    = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_txd", txd, 1'b1);
        check_val("reset_busy", tx_busy, 1'b0);
        check_val("reset_done", tx_done, 1'b0);
        sync_reset = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_txd", txd, 1'b1);

        // 0x55 at 833 clocks per bit
        start_req(833, 8'h55, 1'b0, 1'b0);
        watch_frame("t1", 8'h55, 1'b0, 1'b0, 833, -1, 1'b0);
        repeat (3) @(negedge clk);

        // period below the floor, inputs wiggled during the frame
        start_req(20, 8'hA3, 1'b0, 1'b0);
        watch_frame("t2", 8'hA3, 1'b0, 1'b0, 20, -1, 1'b1);

        // 11-bit frame with TB8 set
        start_req(104, 8'h00, 1'b1, 1'b1);
        watch_frame("t3", 8'h00, 1'b1, 1'b1, 104, -1, 1'b0);
        repeat (2) @(negedge clk);

        // second request mid-frame is ignored
        start_req(150, 8'h3C, 1'b0, 1'b0);
        watch_frame("t4", 8'h3C, 1'b0, 1'b0, 150, 3 * 150 + 7, 1'b0);
        check_val("t4_busy_after", tx_busy, 1'b0);

        // back-to-back: request in the first cycle with tx_busy low
        start_req(110, 8'hC5, 1'b0, 1'b0);
        watch_frame("t5a", 8'hC5, 1'b0, 1'b0, 110, -1, 1'b0);
        start_req(120, 8'h9A, 1'b1, 1'b1);
        watch_frame("t5b", 8'h9A, 1'b1, 1'b1, 120, -1, 1'b0);

        // request coincident with tx_done is dropped
        start_req(104, 8'h81, 1'b0, 1'b0);
        watch_frame("t7", 8'h81, 1'b0, 1'b0, 104, 10 * 104 - 1, 1'b0);
        @(negedge clk);
        check_val("t7_still_idle_busy", tx_busy, 1'b0);
        check_val("t7_still_idle_txd", txd, 1'b1);

        // ceiling clamp: start bit of a 20000 request lasts 10000 clocks, then reset mid-frame
        start_req(20000, 8'hA5, 1'b0, 1'b0);
        c = 0;
        while (txd === 1'b0 && c < 10005) begin
            c++;
            @(negedge clk);
        end
        check_val("t8_start_len_max", c, 10000);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        check_val("t8_reset_busy", tx_busy, 1'b0);

        // reset during data bit 3
        rd = 8'($urandom);
        start_req(104, rd, 1'b0, 1'b0);
        repeat (4 * 104 + 52) @(negedge clk);
        check_val("t6_bit3_before_reset", txd, rd[3]);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        check_val("t6_reset_txd", txd, 1'b1);
        check_val("t6_reset_busy", tx_busy, 1'b0);
        check_val("t6_reset_done", tx_done, 1'b0);
        lows  = 0;
        dones = 0;
        for (int i = 0; i < 3 * 104; i++) begin
            if (txd !== 1'b1) lows++;
            if (tx_done !== 1'b0) dones++;
            @(negedge clk);
        end
        check_val("t6_line_idle_after", lows, 0);
        check_val("t6_no_done_after", dones, 0);

        // randomized frames, random gaps (0 = back-to-back) and random ignored requests
        for (int k = 0; k < 8; k++) begin
            rb  = $urandom_range(0, 330);
            rd  = 8'($urandom);
            r8  = 1'($urandom);
            rn  = 1'($urandom);
            gap = $urandom_range(0, 3);
            inj = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9 * model_period(rb)) : -1;
            repeat (gap) @(negedge clk);
            start_req(rb, rd, r8, rn);
            watch_frame($sformatf("rnd%0d", k), rd, r8, rn, rb, inj, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
